// File: rtl/psola_drain_if.sv
// Bus between psola_drain and its surroundings: frame/tick strobes in,
// BRAM port B read/clear in and out, sample and status strobes out.
interface psola_drain_if #(
  parameter int ADDR_BITS = 12,
  parameter int OUT_WIDTH = 16
);
  logic [11:0]                 window_len_in;
  logic                        window_len_valid_in;
  logic                        sample_tick_in;
  logic [ADDR_BITS-1:0]        rd_addr_out;
  logic [31:0]                 rd_data_in;
  logic [ADDR_BITS-1:0]        clr_addr_out;
  logic                        clr_we_out;
  logic signed [OUT_WIDTH-1:0] sample_out;
  logic                        sample_valid_out;
  logic                        busy_out;
  logic                        frame_done_out;
  logic                        underrun_out;
  logic                        overrun_out;

  modport master (
    output window_len_in, window_len_valid_in, sample_tick_in, rd_data_in,
    input  rd_addr_out, clr_addr_out, clr_we_out, sample_out, sample_valid_out,
           busy_out, frame_done_out, underrun_out, overrun_out
  );

  modport slave (
    input  window_len_in, window_len_valid_in, sample_tick_in, rd_data_in,
    output rd_addr_out, clr_addr_out, clr_we_out, sample_out, sample_valid_out,
           busy_out, frame_done_out, underrun_out, overrun_out
  );
endinterface

// File: rtl/psola_drain.sv
// PSOLA overlap-add buffer drain: on each audio tick reads one accumulated
// word from BRAM port B, rounds/saturates it to a signed sample, and clears
// the word so the next frame accumulates from zero.
module psola_drain #(
  parameter int MAX_EXTENDED  = 2200,
  parameter int FRACTION_BITS = 14,
  parameter int OUT_WIDTH     = 16
) (
  input logic         clk_in,
  input logic         rst_in,
  psola_drain_if.slave bus
);
  localparam int ADDR_BITS = $clog2(MAX_EXTENDED);
  localparam int LEN_BITS  = $clog2(MAX_EXTENDED + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_LAT1 = 3'd3;
  localparam logic [2:0] S_LAT2 = 3'd4;
  localparam logic [2:0] S_EMIT = 3'd5;

  localparam logic signed [32:0] HALF   = 33'sd1 <<< (FRACTION_BITS - 1);
  localparam logic signed [32:0] SAT_HI = (33'sd1 <<< (OUT_WIDTH - 1)) - 33'sd1;
  localparam logic signed [32:0] SAT_LO = -(33'sd1 <<< (OUT_WIDTH - 1));

  logic [2:0]                  state;
  logic [LEN_BITS-1:0]         len;
  logic [LEN_BITS-1:0]         idx;
  logic [LEN_BITS-1:0]         idx_next;
  logic                        last;
  logic                        pend_valid;
  logic [LEN_BITS-1:0]         pend_len;
  logic [LEN_BITS-1:0]         win_len;
  logic [LEN_BITS-1:0]         load_len;
  logic signed [32:0]          rounded;
  logic signed [32:0]          scaled;
  logic signed [OUT_WIDTH-1:0] conv;

  logic [ADDR_BITS-1:0]        rd_addr;
  logic [ADDR_BITS-1:0]        clr_addr;
  logic                        clr_we;
  logic signed [OUT_WIDTH-1:0] sample;
  logic                        sample_valid;
  logic                        frame_done;
  logic                        underrun;
  logic                        overrun;

  assign win_len  = (32'(bus.window_len_in) > 32'(MAX_EXTENDED)) ?
                    LEN_BITS'(MAX_EXTENDED) : LEN_BITS'(bus.window_len_in);
  // a held frame always wins over a strobe arriving on the final EMIT cycle
  assign load_len = pend_valid ? pend_len : win_len;
  assign idx_next = idx + 1'b1;
  assign last     = (idx_next == len);

  // Round half up in 33 bits (no wrap), then saturate to the output width
  always_comb begin
    rounded = $signed({bus.rd_data_in[31], bus.rd_data_in}) + HALF;
    scaled  = rounded >>> FRACTION_BITS;
    if (scaled > SAT_HI)      conv = SAT_HI[OUT_WIDTH-1:0];
    else if (scaled < SAT_LO) conv = SAT_LO[OUT_WIDTH-1:0];
    else                      conv = scaled[OUT_WIDTH-1:0];
  end

  // Drain FSM, pending-frame slot and all registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= S_IDLE;
      len          <= '0;
      idx          <= '0;
      pend_valid   <= 1'b0;
      pend_len     <= '0;
      rd_addr      <= '0;
      clr_addr     <= '0;
      clr_we       <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      clr_we       <= 1'b0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
      overrun      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.sample_tick_in) begin
            sample       <= '0;
            sample_valid <= 1'b1;
            underrun     <= 1'b1;
          end
          if (bus.window_len_valid_in) begin
            len <= win_len;
            idx <= '0;
            if (win_len == '0) frame_done <= 1'b1;
            else               state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.sample_tick_in) begin
            rd_addr <= idx[ADDR_BITS-1:0];
            state   <= S_ADDR;
          end
        end
        S_ADDR: state <= S_LAT1;
        S_LAT1: state <= S_LAT2;
        S_LAT2: begin
          sample       <= conv;
          sample_valid <= 1'b1;
          clr_we       <= 1'b1;
          clr_addr     <= idx[ADDR_BITS-1:0];
          frame_done   <= last;
          state        <= S_EMIT;
        end
        S_EMIT: begin
          idx <= idx_next;
          if (!last) begin
            state <= S_WAIT;
          end else if (pend_valid || bus.window_len_valid_in) begin
            len        <= load_len;
            idx        <= '0;
            pend_valid <= 1'b0;
            if (pend_valid && bus.window_len_valid_in) overrun <= 1'b1;
            if (load_len == '0) begin
              frame_done <= 1'b1;
              state      <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (state != S_IDLE && !(state == S_EMIT && last) && bus.window_len_valid_in) begin
        if (pend_valid) begin
          overrun <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_len   <= win_len;
        end
      end
    end
  end

  assign bus.rd_addr_out      = rd_addr;
  assign bus.clr_addr_out     = clr_addr;
  assign bus.clr_we_out       = clr_we;
  assign bus.sample_out       = sample;
  assign bus.sample_valid_out = sample_valid;
  assign bus.busy_out         = (state != S_IDLE);
  assign bus.frame_done_out   = frame_done;
  assign bus.underrun_out     = underrun;
  assign bus.overrun_out      = overrun;
endmodule

// File: tb/tb_psola_drain.sv
// Directed bench for psola_drain with a 2-cycle-latency BRAM model.
module tb_psola_drain;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  psola_drain_if #(.ADDR_BITS(12), .OUT_WIDTH(16)) bus ();

  psola_drain #(.MAX_EXTENDED(2200), .FRACTION_BITS(14), .OUT_WIDTH(16)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // BRAM port B model: read data valid 2 cycles after address; clears and bench preloads
  logic [31:0] mem [2200] = '{default: '0};
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  assign bus.rd_data_in = d2;
  always @(posedge clk) begin
    d1 <= (bus.rd_addr_out < 12'd2200) ? mem[bus.rd_addr_out] : 32'hDEAD_BEEF;
    d2 <= d1;
    if (pl_we) mem[pl_addr] <= pl_data;
    if (bus.clr_we_out && bus.clr_addr_out < 12'd2200) mem[bus.clr_addr_out] <= '0;
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_we = 1'b0;
  endtask

  task automatic strobe(input logic [11:0] l);
    @(negedge clk); bus.window_len_valid_in = 1'b1; bus.window_len_in = l;
    @(negedge clk); bus.window_len_valid_in = 1'b0;
  endtask

  // Drives one tick and captures what the drain shows 1 and 4 cycles later
  task automatic tick_and_wait(output logic [11:0] ra, output logic early, output logic v,
                               output logic signed [15:0] s, output logic we,
                               output logic [11:0] ca, output logic fd);
    @(negedge clk); bus.sample_tick_in = 1'b1;
    @(negedge clk); bus.sample_tick_in = 1'b0;
    ra = bus.rd_addr_out;
    early = bus.sample_valid_out | bus.clr_we_out;
    repeat (2) begin
      @(negedge clk);
      early = early | bus.sample_valid_out | bus.clr_we_out;
    end
    @(negedge clk);
    v = bus.sample_valid_out; s = bus.sample_out; we = bus.clr_we_out;
    ca = bus.clr_addr_out; fd = bus.frame_done_out;
  endtask

  task automatic test_reset();
    bus.window_len_in = '0; bus.window_len_valid_in = 1'b0; bus.sample_tick_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy_out); end
    checks++; if (bus.sample_out !== 16'sd0) begin errors++; $display("FAIL reset_sample: got %0d expected 0", bus.sample_out); end
    checks++; if (bus.rd_addr_out !== 12'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", bus.rd_addr_out); end
    checks++;
    if ({bus.sample_valid_out, bus.clr_we_out, bus.frame_done_out, bus.underrun_out, bus.overrun_out} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000",
        {bus.sample_valid_out, bus.clr_we_out, bus.frame_done_out, bus.underrun_out, bus.overrun_out});
    end
  endtask

  task automatic test_basic_frame();
    logic [31:0] words [4] = '{32'h0000_4000, 32'h0000_2000, 32'hFFFF_C000, 32'h0};
    logic signed [15:0] exp_s [4] = '{16'sd1, 16'sd1, -16'sd1, 16'sd0};
    logic [11:0] ra, ca; logic early, v, we, fd; logic signed [15:0] s;
    for (int i = 0; i < 4; i++) preload(12'(i), words[i]);
    strobe(12'd4);
    checks++; if (bus.busy_out !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bus.busy_out); end
    for (int i = 0; i < 4; i++) begin
      tick_and_wait(ra, early, v, s, we, ca, fd);
      checks++; if (ra !== 12'(i)) begin errors++; $display("FAIL basic_rd_addr[%0d]: got %0d expected %0d", i, ra, i); end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL basic_latency[%0d]: got early strobe %b expected 0", i, early); end
      checks++; if (v !== 1'b1 || s !== exp_s[i]) begin errors++; $display("FAIL basic_sample[%0d]: got valid=%b %0d expected valid=1 %0d", i, v, s, exp_s[i]); end
      checks++; if (we !== 1'b1 || ca !== 12'(i)) begin errors++; $display("FAIL basic_clear[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", i, we, ca, i); end
      checks++; if (fd !== (i == 3)) begin errors++; $display("FAIL basic_done[%0d]: got %b expected %b", i, fd, (i == 3)); end
      repeat (3) @(negedge clk);
    end
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy %b expected 0", bus.busy_out); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[i] !== 32'h0) begin errors++; $display("FAIL basic_cleared[%0d]: got %h expected 0", i, mem[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] words [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_1FFF, 32'h0000_2000};
    logic signed [15:0] exp_s [4] = '{16'sd32767, -16'sd32768, 16'sd0, 16'sd1};
    logic [11:0] ra, ca; logic early, v, we, fd; logic signed [15:0] s;
    for (int i = 0; i < 4; i++) preload(12'(i), words[i]);
    strobe(12'd4);
    for (int i = 0; i < 4; i++) begin
      tick_and_wait(ra, early, v, s, we, ca, fd);
      checks++; if (v !== 1'b1 || s !== exp_s[i]) begin errors++; $display("FAIL sat_sample[%0d]: got valid=%b %0d expected valid=1 %0d", i, v, s, exp_s[i]); end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_underrun();
    @(negedge clk); bus.sample_tick_in = 1'b1;
    @(negedge clk); bus.sample_tick_in = 1'b0;
    checks++;
    if (bus.sample_valid_out !== 1'b1 || bus.underrun_out !== 1'b1 || bus.sample_out !== 16'sd0) begin
      errors++; $display("FAIL underrun_pulse: got valid=%b underrun=%b sample=%0d expected 1 1 0",
        bus.sample_valid_out, bus.underrun_out, bus.sample_out);
    end
    @(negedge clk);
    checks++;
    if (bus.sample_valid_out !== 1'b0 || bus.underrun_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      errors++; $display("FAIL underrun_once: got valid=%b underrun=%b busy=%b expected 0 0 0",
        bus.sample_valid_out, bus.underrun_out, bus.busy_out);
    end
  endtask

  task automatic test_queueing();
    // frame 2 rereads addresses 0..1 already cleared by frame 1
    logic signed [15:0] exp_s [5] = '{16'sd1, 16'sd2, 16'sd0, 16'sd0, 16'sd3};
    logic [11:0] ra, ca; logic early, v, we, fd; logic signed [15:0] s;
    int nsamp = 0; int ndone = 0;
    preload(12'd0, 32'h0000_4000);
    preload(12'd1, 32'h0000_8000);
    preload(12'd2, 32'h0000_C000);
    strobe(12'd2);
    for (int i = 0; i < 5; i++) begin
      tick_and_wait(ra, early, v, s, we, ca, fd);
      nsamp += int'(v); ndone += int'(fd);
      checks++; if (v !== 1'b1 || s !== exp_s[i]) begin errors++; $display("FAIL queue_sample[%0d]: got valid=%b %0d expected valid=1 %0d", i, v, s, exp_s[i]); end
      if (i == 0) begin
        strobe(12'd3);
        checks++; if (bus.overrun_out !== 1'b0) begin errors++; $display("FAIL queue_pending: got overrun %b expected 0", bus.overrun_out); end
        strobe(12'd1);
        checks++; if (bus.overrun_out !== 1'b1) begin errors++; $display("FAIL queue_overrun: got overrun %b expected 1", bus.overrun_out); end
      end else begin
        repeat (3) @(negedge clk);
      end
    end
    checks++; if (nsamp !== 5 || ndone !== 2) begin errors++; $display("FAIL queue_totals: got %0d samples %0d done expected 5 and 2", nsamp, ndone); end
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL queue_idle: got busy %b expected 0", bus.busy_out); end
  endtask

  task automatic test_len_zero();
    logic saw_we = 1'b0;
    strobe(12'd0);
    checks++; if (bus.frame_done_out !== 1'b1 || bus.busy_out !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b busy=%b expected 1 0", bus.frame_done_out, bus.busy_out); end
    repeat (6) begin @(negedge clk); saw_we = saw_we | bus.clr_we_out; end
    checks++; if (saw_we !== 1'b0) begin errors++; $display("FAIL zero_no_clear: got clr_we %b expected 0", saw_we); end
  endtask

  task automatic test_ignored_tick();
    int nvalid = 0;
    logic [11:0] ra, ca; logic early, v, we, fd; logic signed [15:0] s;
    preload(12'd0, 32'h0000_4000);
    preload(12'd1, 32'h0000_4000);
    strobe(12'd2);
    @(negedge clk); bus.sample_tick_in = 1'b1;
    @(negedge clk); bus.sample_tick_in = 1'b0;
    @(negedge clk); bus.sample_tick_in = 1'b1;
    @(negedge clk); bus.sample_tick_in = 1'b0;
    repeat (10) begin @(negedge clk); nvalid += int'(bus.sample_valid_out); end
    checks++; if (nvalid !== 1 || bus.busy_out !== 1'b1) begin errors++; $display("FAIL ignored_tick: got %0d samples busy=%b expected 1 sample busy=1", nvalid, bus.busy_out); end
    tick_and_wait(ra, early, v, s, we, ca, fd);
    checks++; if (ra !== 12'd1 || ca !== 12'd1 || fd !== 1'b1) begin errors++; $display("FAIL ignored_resume: got rd=%0d clr=%0d done=%b expected 1 1 1", ra, ca, fd); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clamp();
    int nsamp = 0; int ndone = 0; int nearly = 0;
    logic [11:0] ra, ca; logic early, v, we, fd; logic signed [15:0] s;
    logic [11:0] last_ca = '0; logic last_fd = 1'b0;
    preload(12'd2199, 32'h0000_4000);
    strobe(12'd4000);
    for (int i = 0; i < 2200; i++) begin
      tick_and_wait(ra, early, v, s, we, ca, fd);
      nsamp += int'(v); ndone += int'(fd); nearly += int'(early);
      last_ca = ca; last_fd = fd;
    end
    checks++; if (nsamp !== 2200 || nearly !== 0) begin errors++; $display("FAIL clamp_count: got %0d samples %0d early expected 2200 0", nsamp, nearly); end
    checks++; if (last_ca !== 12'd2199 || s !== 16'sd1) begin errors++; $display("FAIL clamp_last: got clr=%0d sample=%0d expected 2199 1", last_ca, s); end
    checks++; if (ndone !== 1 || last_fd !== 1'b1) begin errors++; $display("FAIL clamp_done: got %0d done last=%b expected 1 1", ndone, last_fd); end
    @(negedge clk);
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL clamp_idle: got busy %b expected 0", bus.busy_out); end
  endtask

  task automatic test_async_reset();
    logic [11:0] ra, ca; logic early, v, we, fd; logic signed [15:0] s;
    preload(12'd0, 32'h0000_4000);
    preload(12'd1, 32'h0000_8000);
    strobe(12'd2);
    tick_and_wait(ra, early, v, s, we, ca, fd);
    repeat (3) @(negedge clk);
    @(negedge clk); bus.sample_tick_in = 1'b1;
    @(negedge clk); bus.sample_tick_in = 1'b0;
    checks++; if (bus.rd_addr_out !== 12'd1 || bus.sample_out !== 16'sd1) begin errors++; $display("FAIL areset_pre: got rd=%0d sample=%0d expected 1 1", bus.rd_addr_out, bus.sample_out); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy_out !== 1'b0 || bus.rd_addr_out !== 12'd0 || bus.sample_out !== 16'sd0 || bus.clr_addr_out !== 12'd0) begin
      errors++; $display("FAIL areset_outputs: got busy=%b rd=%0d sample=%0d clr=%0d expected all 0",
        bus.busy_out, bus.rd_addr_out, bus.sample_out, bus.clr_addr_out);
    end
    @(negedge clk); rst_n = 1'b1;
    preload(12'd0, 32'h0000_8000);
    strobe(12'd1);
    tick_and_wait(ra, early, v, s, we, ca, fd);
    checks++; if (ra !== 12'd0 || s !== 16'sd2 || ca !== 12'd0 || fd !== 1'b1) begin errors++; $display("FAIL areset_restart: got rd=%0d sample=%0d clr=%0d done=%b expected 0 2 0 1", ra, s, ca, fd); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_saturation();
    test_underrun();
    test_queueing();
    test_len_zero();
    test_ignored_tick();
    test_clamp();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
